// File: rtl/sum_bcd_scan_ctrl_pkg.sv
// Shared definitions for the sum-to-BCD scan controller: FSM encoding,
// seven-segment patterns (active-low, index 0 = segment a) and defaults.
package sum_bcd_scan_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int REFRESH_DIV_DEFAULT = 50000;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    localparam logic [0:6] SEG_LUT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Values 10..15 are not valid BCD and show only the g segment.
    function automatic logic [0:6] bcd_to_seg(input logic [3:0] bcd);
        if (bcd < 4'd10) begin
            return SEG_LUT[bcd];
        end
        return SEG_DASH;
    endfunction

endpackage

// File: rtl/sum_bcd_scan_ctrl_adder.sv
// Ripple-carry adder producing an N+1 bit sum from two N-bit operands.
module sum_bcd_scan_ctrl_adder #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N:0]   o_sum
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b0;

    // One full-adder cell per operand bit.
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_sum[N] = w_carry[N];

endmodule

// File: rtl/sum_bcd_scan_ctrl_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
module sum_bcd_scan_ctrl_seg7_decoder
    import sum_bcd_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [0:6] o_seg
);

    // Table lookup; non-BCD codes fall back to the dash pattern.
    always_comb begin
        o_seg = bcd_to_seg(i_bcd);
    end

endmodule

// File: rtl/sum_bcd_scan_ctrl.sv
// Adds two operands, splits the sum into tens/units by repeated
// subtraction of ten, and scans both digits onto one segment bus.
module sum_bcd_scan_ctrl
    import sum_bcd_scan_ctrl_pkg::*;
#(
    parameter int N           = 5,
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter int SEGMENTOS   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         A,
    input  logic [N-1:0]         B,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           decenas,
    output logic [3:0]           unidades,
    output logic [0:SEGMENTOS-1] seg,
    output logic [1:0]           an
);

    localparam int EXT_W = 7;
    localparam int CW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [1:0]       r_state;
    logic [N:0]       r_rem;
    logic [3:0]       r_tens;
    logic [3:0]       r_units;
    logic [3:0]       r_dec;
    logic [3:0]       r_uni;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic             r_sel;
    logic [1:0]       r_an;
    logic [0:6]       r_seg;

    logic [N:0]       w_sum;
    logic [EXT_W-1:0] w_rem_ext;
    logic [3:0]       w_dec_next;
    logic [3:0]       w_uni_next;
    logic             w_wrap;
    logic             w_sel_next;
    logic [3:0]       w_digit;
    logic [0:6]       w_seg_dec;

    sum_bcd_scan_ctrl_adder #(.N(N)) u_adder (
        .i_a   (A),
        .i_b   (B),
        .o_sum (w_sum)
    );

    assign w_rem_ext = {{(EXT_W-N-1){1'b0}}, r_rem};

    // Conversion FSM: latch the sum, peel off tens, then commit both digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_tens  <= '0;
            r_units <= '0;
            r_dec   <= '0;
            r_uni   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rem   <= w_sum;
                        r_tens  <= '0;
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (w_rem_ext >= EXT_W'(10)) begin
                        r_rem  <= r_rem - (N+1)'(10);
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_units <= w_rem_ext[3:0];
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_dec   <= r_tens;
                    r_uni   <= r_units;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Digit values as they will be after this edge, so the display
    // register picks up a commit on the same edge as decenas/unidades.
    always_comb begin
        w_dec_next = r_dec;
        w_uni_next = r_uni;
        if (r_state == ST_COMMIT) begin
            w_dec_next = r_tens;
            w_uni_next = r_units;
        end
    end

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_sel_next = w_wrap ? ~r_sel : r_sel;
    assign w_digit    = w_sel_next ? w_dec_next : w_uni_next;

    sum_bcd_scan_ctrl_seg7_decoder u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    // Scan counter and display outputs; an and seg load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_an  <= 2'b10;
            r_seg <= SEG_LUT[0];
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            r_sel <= w_sel_next;
            r_an  <= w_sel_next ? 2'b01 : 2'b10;
            if (w_sel_next && (w_dec_next == 4'd0)) begin
                r_seg <= SEG_BLANK;
            end else begin
                r_seg <= w_seg_dec;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign decenas  = r_dec;
    assign unidades = r_uni;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: tb/tb_sum_bcd_scan_ctrl.sv
// Directed and randomised checks of the sum/BCD scan controller against a
// latency/arithmetic reference model, sampled 1 time unit after each edge.
module tb_sum_bcd_scan_ctrl;

    localparam int N   = 5;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] A = '0;
    logic [4:0] B = '0;
    logic       busy, done;
    logic [3:0] decenas, unidades;
    logic [0:6] seg;
    logic [1:0] an;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cd   = 0;
    int m_pt   = 0;
    int m_pu   = 0;
    int m_dec  = 0;
    int m_uni  = 0;
    int m_done = 0;
    int sc     = 0;

    logic [0:6] enc [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    sum_bcd_scan_ctrl #(.N(N), .REFRESH_DIV(DIV), .SEGMENTOS(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .decenas  (decenas),
        .unidades (unidades),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare every output.
    task automatic tick();
        logic       rs;
        logic       s;
        int         sum;
        logic [0:6] exp_seg;
        int         sel;
        rs  = rst;
        s   = start;
        sum = int'(A) + int'(B);
        @(posedge clk);
        #1;
        if (rs) begin
            m_cd = 0; m_done = 0; m_dec = 0; m_uni = 0; sc = 0;
        end else begin
            sc++;
            if (m_cd == 0) begin
                m_done = 0;
                if (s) begin
                    m_cd = sum / 10 + 2;
                    m_pt = sum / 10;
                    m_pu = sum % 10;
                end
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    m_dec = m_pt; m_uni = m_pu; m_done = 1;
                end else begin
                    m_done = 0;
                end
            end
        end
        sel = (sc / DIV) % 2;
        if (sel == 1) exp_seg = (m_dec == 0) ? 7'b1111111 : enc[m_dec];
        else          exp_seg = enc[m_uni];
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), (m_cd > 0) ? 32'd1 : 32'd0);
        chk("decenas", 32'(decenas), 32'(m_dec));
        chk("unidades", 32'(unidades), 32'(m_uni));
        chk("an", 32'(an), (sel == 1) ? 32'd1 : 32'd2);
        chk("seg", 32'(seg), 32'(exp_seg));
    endtask

    // Start one conversion and wait (bounded) for its done pulse; random
    // start/operand noise during the wait must be ignored by the DUT.
    task automatic run_conv(input int a, input int b, input bit noise, output int lat);
        A = 5'(a); B = 5'(b); start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (noise && ($urandom % 3 == 0)) begin
                start = 1'b1; A = 5'($urandom); B = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'((a + b) / 10 + 2));
        chk("res_tens", 32'(decenas), 32'((a + b) / 10));
        chk("res_units", 32'(unidades), 32'((a + b) % 10));
    endtask

    initial begin
        int lat;
        int cnt;
        int last;
        bit found;

        // Reset and idle scanning
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_an", 32'(an), 32'd2);
        chk("rst_seg", 32'(seg), 32'(7'b0000001));
        for (int i = 0; i < 12; i++) tick();

        // 31 + 31 = 62
        run_conv(31, 31, 1'b0, lat);
        chk("l62", 32'(lat), 32'd8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (an == 2'b01) found = 1'b1;
        end
        chk("tens_found", 32'(found), 32'd1);
        chk("seg_six", 32'(seg), 32'(7'b0100000));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (an == 2'b10) found = 1'b1;
        end
        chk("units_found", 32'(found), 32'd1);
        chk("seg_two", 32'(seg), 32'(7'b0010010));

        // 4 + 5 and 5 + 5
        run_conv(4, 5, 1'b0, lat);
        chk("l9", 32'(lat), 32'd2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (an == 2'b01) found = 1'b1;
        end
        chk("blank_found", 32'(found), 32'd1);
        chk("seg_blank", 32'(seg), 32'(7'b1111111));
        run_conv(5, 5, 1'b0, lat);
        chk("l10", 32'(lat), 32'd3);

        // Extra start during CONV is ignored
        A = 5'd31; B = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        tick(); tick();
        A = 5'd1; B = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        chk("one_done", 32'(cnt), 32'd1);
        chk("ign_tens", 32'(decenas), 32'd6);
        chk("ign_units", 32'(unidades), 32'd2);

        // Reset during CONV
        A = 5'd31; B = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
        chk("abort_nodone", 32'(cnt), 32'd0);
        chk("abort_tens", 32'(decenas), 32'd0);
        chk("abort_units", 32'(unidades), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run_conv(3, 4, 1'b0, lat);

        // start held high: back-to-back conversions of 10
        A = 5'd10; B = 5'd0; start = 1'b1;
        cnt = 0; last = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) begin
                if (last >= 0) chk("period", 32'(i - last), 32'd4);
                last = i;
                cnt++;
            end
        end
        start = 1'b0;
        chk("held_count", 32'(cnt), 32'd5);
        chk("held_tens", 32'(decenas), 32'd1);
        chk("held_units", 32'(unidades), 32'd0);
        tick(); tick(); tick(); tick();

        // Randomised conversions with noise on start/operands while busy
        for (int k = 0; k < 16; k++) begin
            run_conv(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b1, lat);
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                A = 5'($urandom); B = 5'($urandom);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
